// File: rtl/priority_encoder.sv
// 4-to-2 priority encoder with registered outputs.
// d3 has highest priority, d0 lowest. {y1,y0} holds the index of the highest
// active request one clock after the inputs are sampled; v flags that any
// request was present. Code 00 with v=0 means "no request".
module priority_encoder (
    input  logic clk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    output logic y0,
    output logic y1,
    output logic v
);

    logic [1:0] enc;
    logic       any;

    // Combinational priority decode of the current request lines.
    always_comb begin
        enc = '0;
        any = d0 | d1 | d2 | d3;
        if (d3) begin
            enc = 2'b11;
        end else if (d2) begin
            enc = 2'b10;
        end else if (d1) begin
            enc = 2'b01;
        end else begin
            enc = 2'b00;
        end
    end

    // Output register; asynchronous reset drops the result immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y1 <= 1'b0;
            y0 <= 1'b0;
            v  <= 1'b0;
        end else begin
            y1 <= enc[1];
            y0 <= enc[0];
            v  <= any;
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder using an expected-value queue.
module tb_priority_encoder;

    logic clk = 1'b0;
    logic rst;
    logic d0, d1, d2, d3;
    logic y0, y1, v;
    logic [2:0] got;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [2:0] sb [$];

    priority_encoder dut (
        .clk (clk),
        .rst (rst),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y0  (y0),
        .y1  (y1),
        .v   (v)
    );

    always #5 clk = ~clk;

    assign got = {y1, y0, v};

    // Reference model: returns {y1, y0, v} for request vector d3..d0.
    function automatic logic [2:0] model(input logic [3:0] d);
        if (d[3])      return 3'b111;
        else if (d[2]) return 3'b101;
        else if (d[1]) return 3'b011;
        else if (d[0]) return 3'b001;
        else           return 3'b000;
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got {y1,y0,v}=%b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] vec);
        @(negedge clk);
        {d3, d2, d1, d0} = vec;
        sb.push_back(model(vec));
    endtask

    task automatic collect(input string tag);
        @(posedge clk);
        #1;
        if (sb.size() == 0) check({tag, "_sb_empty"}, 3'b001, 3'b000);
        else                check(tag, got, sb.pop_front());
    endtask

    task automatic apply(input logic [3:0] vec, input string tag);
        drive(vec);
        collect(tag);
    endtask

    initial begin
        logic [3:0] directed [5];
        directed = '{4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b1010};

        // Reset held: outputs stay zero while inputs toggle and clock runs.
        rst = 1'b1;
        {d3, d2, d1, d0} = 4'b0000;
        #1;
        check("rst_initial", got, 3'b000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {d3, d2, d1, d0} = 4'($urandom_range(1, 15));
            #2;
            check("rst_hold_mid", got, 3'b000);
            @(posedge clk);
            #1;
            check("rst_hold_edge", got, 3'b000);
        end

        // First edge after release registers the current inputs.
        @(negedge clk);
        rst = 1'b0;
        {d3, d2, d1, d0} = 4'b0011;
        sb.push_back(model(4'b0011));
        collect("post_rst");

        foreach (directed[i]) apply(directed[i], "directed");

        // Exhaustive sweep, one vector per cycle.
        for (int i = 0; i < 16; i++) apply(4'(i), "sweep");

        for (int i = 0; i < 20; i++) apply(4'($urandom_range(0, 15)), "random");

        // Pulse between edges must not be captured.
        apply(4'b0000, "glitch_pre");
        #2;
        {d3, d2, d1, d0} = 4'b1000;
        #1;
        check("glitch_mid", got, 3'b000);
        #1;
        {d3, d2, d1, d0} = 4'b0000;
        sb.push_back(model(4'b0000));
        collect("glitch_edge");

        // Asynchronous reset between edges clears outputs immediately.
        apply(4'b1111, "pre_async");
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", got, 3'b000);
        @(posedge clk);
        #1;
        check("rst_async_edge", got, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(4'b1111));
        collect("rst_release");

        if (sb.size() != 0) check("sb_leftover", 3'(sb.size()), 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
